// File: rtl/ov7670_pkg.sv
// Shared constants and state encoding for the OV7670 SCCB configuration block.
package ov7670_pkg;

  localparam logic [7:0]  SCCB_ID_W = 8'h42;
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_FIN
  } sccb_state_t;

endpackage

// File: rtl/ov7670_sccb_rom.sv
// Register table for the OV7670: soft reset, settle delay, then RGB444 QVGA setup.
module ov7670_sccb_rom
  import ov7670_pkg::*;
(
  input  logic [7:0]  i_idx,
  output logic [15:0] o_entry
);

  always_comb begin
    o_entry = ROM_END;
    case (i_idx)
      8'd0:    o_entry = 16'h1280;  // COM7 soft reset
      8'd1:    o_entry = ROM_DELAY;
      8'd2:    o_entry = 16'h1214;  // COM7: QVGA, RGB
      8'd3:    o_entry = 16'h8C02;  // RGB444 enable, xR GB
      8'd4:    o_entry = 16'h40D0;  // COM15 full range
      8'd5:    o_entry = 16'h1101;
      8'd6:    o_entry = 16'h3A04;
      8'd7:    o_entry = 16'h0C04;  // COM3 scaling for QVGA
      8'd8:    o_entry = 16'h3E19;
      8'd9:    o_entry = 16'h7211;
      8'd10:   o_entry = 16'h73F1;
      8'd11:   o_entry = 16'hA202;
      default: o_entry = ROM_END;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks the register ROM and issues one 3-phase SCCB write per entry; raises a
// sticky done once the end marker is reached.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int SCCB_HZ      = 100_000,
  parameter int QTR          = CLK_HZ / (4 * SCCB_HZ),
  parameter int DELAY_CYCLES = 12_000
) (
  input  logic clk_12,
  input  logic reset_n,
  input  logic go,
  output logic sioc,
  output logic siod_o,
  output logic siod_oe,
  output logic busy,
  output logic done
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int DW = $clog2(DELAY_CYCLES + 1);

  sccb_state_t     r_state, w_state_nxt;
  logic [7:0]      r_idx;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_phase;
  logic [4:0]      r_bit;
  logic [DW-1:0]   r_dcnt;
  logic [26:0]     r_frame;
  logic [15:0]     w_entry;
  logic            w_qwrap, w_last_q, w_dly_end, w_ack_slot;
  logic            w_sioc, w_siod_o, w_siod_oe;

  ov7670_sccb_rom u_rom (
    .i_idx   (r_idx),
    .o_entry (w_entry)
  );

  assign w_qwrap    = (r_qcnt == QW'(QTR - 1));
  assign w_last_q   = w_qwrap && (r_phase == 2'd3);
  assign w_dly_end  = (r_dcnt == DW'(DELAY_CYCLES - 1));
  assign w_ack_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);

  // State register plus the counters and shift frame that travel with it.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_qcnt  <= '0;
      r_phase <= '0;
      r_bit   <= '0;
      r_dcnt  <= '0;
      r_frame <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_idx <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_qcnt  <= '0;
          r_phase <= '0;
          r_bit   <= '0;
          r_dcnt  <= '0;
          // Don't-care (acknowledge) slots carry 1 so a released line matches.
          r_frame <= {SCCB_ID_W, 1'b1, w_entry[15:8], 1'b1, w_entry[7:0], 1'b1};
        end
        S_START, S_BITS, S_STOP, S_GAP: begin
          r_qcnt <= w_qwrap ? '0 : r_qcnt + 1'b1;
          if (w_qwrap) r_phase <= r_phase + 1'b1;
          if (r_state == S_BITS && w_last_q) begin
            r_bit   <= r_bit + 1'b1;
            r_frame <= {r_frame[25:0], 1'b1};
          end
          if (r_state == S_GAP && w_last_q) r_idx <= r_idx + 1'b1;
        end
        S_DELAY: begin
          if (w_dly_end) begin
            r_dcnt <= '0;
            r_idx  <= r_idx + 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (go) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_entry == ROM_END)        w_state_nxt = S_FIN;
        else if (w_entry == ROM_DELAY) w_state_nxt = S_DELAY;
        else                           w_state_nxt = S_START;
      end
      S_START: if (w_last_q) w_state_nxt = S_BITS;
      S_BITS:  if (w_last_q && r_bit == 5'd26) w_state_nxt = S_STOP;
      S_STOP:  if (w_last_q) w_state_nxt = S_GAP;
      S_GAP:   if (w_last_q) w_state_nxt = S_FETCH;
      S_DELAY: if (w_dly_end) w_state_nxt = S_FETCH;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus levels per quarter; idle is SIOC high with SIOD released.
  always_comb begin
    w_sioc    = 1'b1;
    w_siod_o  = 1'b1;
    w_siod_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_sioc    = (r_phase != 2'd3);
        w_siod_o  = (r_phase == 2'd0);
        w_siod_oe = (r_phase != 2'd0);
      end
      S_BITS: begin
        w_sioc    = r_phase[1];
        w_siod_o  = w_ack_slot ? 1'b1 : r_frame[26];
        w_siod_oe = !w_ack_slot;
      end
      S_STOP: begin
        w_sioc    = (r_phase != 2'd0);
        w_siod_o  = r_phase[1];
        w_siod_oe = !r_phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      sioc    <= 1'b1;
      siod_o  <= 1'b1;
      siod_oe <= 1'b0;
    end else begin
      sioc    <= w_sioc;
      siod_o  <= w_siod_o;
      siod_oe <= w_siod_oe;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Directed bench: decodes the SCCB bus into writes and compares against the
// expected register table, bus timing and busy/done behaviour.
module tb_ov7670_sccb_config;

  logic clk_12 = 1'b0;
  logic reset_n, go;
  logic sioc, siod_o, siod_oe, busy, done;

  ov7670_sccb_config #(.DELAY_CYCLES(100)) dut (
    .clk_12  (clk_12),
    .reset_n (reset_n),
    .go      (go),
    .sioc    (sioc),
    .siod_o  (siod_o),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_12 = ~clk_12;

  int cyc = 0;
  always @(posedge clk_12) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writes in table order, delay marker excluded.
  logic [15:0] exp_tab [11] = '{16'h1280, 16'h1214, 16'h8C02, 16'h40D0, 16'h1101,
                                16'h3A04, 16'h0C04, 16'h3E19, 16'h7211, 16'h73F1,
                                16'hA202};

  // ---------------- bus monitor ----------------
  logic mon_en = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, sda;
  logic edge_sda [40];
  logic edge_oe  [40];
  int   n_edges = 0;
  int   tx_cnt = 0, start_cnt = 0;
  int   st_cyc [16];
  int   sp_cyc [16];
  logic [23:0] got_tx;

  always @(negedge clk_12) begin
    sda = siod_oe ? siod_o : 1'b1;
    if (mon_en) begin
      if (prev_scl && sioc && prev_sda && !sda) begin
        if (start_cnt < 16) st_cyc[start_cnt] = cyc;
        start_cnt++;
        n_edges = 0;
      end else if (prev_scl && sioc && !prev_sda && sda) begin
        // The last SIOC rise belongs to the stop condition itself.
        check("bit_edges", n_edges - 1, 27);
        check("ack_slots_released", {29'd0, edge_oe[8], edge_oe[17], edge_oe[26]}, 0);
        for (int i = 0; i < 8; i++) begin
          got_tx[23-i] = edge_sda[i];
          got_tx[15-i] = edge_sda[9+i];
          got_tx[7-i]  = edge_sda[18+i];
        end
        if (exp_q.size() == 0) check("tx_unexpected", {8'd0, got_tx}, 0);
        else                   check("tx_data", {8'd0, got_tx}, {8'd0, exp_q.pop_front()});
        if (tx_cnt < 16) sp_cyc[tx_cnt] = cyc;
        tx_cnt++;
      end else if (!prev_scl && sioc) begin
        if (n_edges < 40) begin
          edge_sda[n_edges] = sda;
          edge_oe[n_edges]  = siod_oe;
        end
        n_edges++;
      end
    end
    prev_scl = sioc;
    prev_sda = sda;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_go();
    @(negedge clk_12);
    go = 1'b1;
    @(negedge clk_12);
    go = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sioc"},    sioc,    1'b1);
    check({tag, "_siod_o"},  siod_o,  1'b1);
    check({tag, "_siod_oe"}, siod_oe, 1'b0);
    check({tag, "_busy"},    busy,    1'b0);
    check({tag, "_done"},    done,    1'b0);
  endtask

  // ---------------- main sequence ----------------
  int go_cyc;
  int t;
  int drops;
  logic pb;

  initial begin
    reset_n = 1'b0;
    go      = 1'b0;
    repeat (3) @(negedge clk_12);
    check_reset_state("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_12);
    check_reset_state("idle");

    // First pass: full table
    foreach (exp_tab[i]) exp_q.push_back({8'h42, exp_tab[i]});
    mon_en = 1'b1;
    @(negedge clk_12);
    go = 1'b1;
    @(negedge clk_12);
    go = 1'b0;
    go_cyc = cyc;
    check("busy_after_go", busy, 1'b1);
    check("sioc_idle_after_go", sioc, 1'b1);

    t = 0;
    while (start_cnt < 1 && t < 200) begin @(negedge clk_12); t++; end
    check("first_start_seen", start_cnt, 1);
    check("go_to_start_edge", st_cyc[0] - go_cyc, 32);

    // go in the middle of the first write's data bits
    repeat (500) @(negedge clk_12);
    go = 1'b1;
    @(negedge clk_12);
    go = 1'b0;
    check("busy_after_go_in_bits", busy, 1'b1);
    check("done_low_mid_run", done, 1'b0);

    t = 0;
    pb = busy;
    while (!done && t < 60000) begin
      pb = busy;
      @(negedge clk_12);
      t++;
    end
    check("done_reached", done, 1'b1);
    check("busy_before_done_edge", pb, 1'b1);
    check("busy_at_done_edge", busy, 1'b0);
    check("tx_count", tx_cnt, 11);
    check("exp_q_drained", exp_q.size(), 0);
    check("delay_spacing", st_cyc[1] - sp_cyc[0], 312);
    check("gap_spacing", st_cyc[2] - sp_cyc[1], 211);

    drops = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_12);
      if (!done || busy || !sioc || siod_oe) drops++;
    end
    check("done_sticky_10k", drops, 0);

    // Re-run: expect the soft-reset write first again
    tx_cnt    = 0;
    start_cnt = 0;
    exp_q.push_back(24'h421280);
    pulse_go();
    check("rerun_done_cleared", done, 1'b0);
    check("rerun_busy", busy, 1'b1);
    t = 0;
    while (tx_cnt < 1 && t < 5000) begin @(negedge clk_12); t++; end
    check("rerun_first_tx", tx_cnt, 1);
    check("rerun_exp_q_drained", exp_q.size(), 0);

    // Reset in the middle of the next write's first byte
    t = 0;
    while (start_cnt < 2 && t < 2000) begin @(negedge clk_12); t++; end
    check("rerun_second_start", start_cnt, 2);
    repeat (600) @(negedge clk_12);
    mon_en = 1'b0;
    check("mid_byte_sioc_low", sioc, 1'b0);
    check("mid_byte_oe_driven", siod_oe, 1'b1);
    check("mid_byte_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sioc", sioc, 1'b1);
    check("async_rst_oe", siod_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk_12);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_12);
    check_reset_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
